// File: rtl/engine_filter_cond_result_stage_pkg.sv
// Shared types for the filter-condition result stage: pass policy,
// configuration word and FIFO entry layout.
package engine_filter_cond_result_stage_pkg;

    typedef logic [63:0] MemoryPacketData;

    typedef enum logic [1:0] {
        PASS_TRUE  = 2'd0,
        PASS_FALSE = 2'd1,
        PASS_ALL   = 2'd2
    } FilterCondPassMode;

    typedef struct packed {
        FilterCondPassMode pass_mode;
        logic              break_on_false;
    } FilterCondResultConfig;

    typedef struct packed {
        MemoryPacketData data;
        logic            flag;
    } FilterCondFifoEntry;

    // Keep decision for one packet; the unused encoding keeps nothing.
    function automatic logic keep_packet(input FilterCondPassMode mode, input logic flag);
        logic keep;
        case (mode)
            PASS_TRUE:  keep = flag;
            PASS_FALSE: keep = ~flag;
            PASS_ALL:   keep = 1'b1;
            default:    keep = 1'b0;
        endcase
        return keep;
    endfunction

endpackage

// File: rtl/engine_filter_cond_result_fifo.sv
// Show-ahead FIFO with a registered head entry. Pointers carry one extra
// wrap bit so full/empty are distinguished by the MSB compare.
module engine_filter_cond_result_fifo
    import engine_filter_cond_result_stage_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               ap_clk,
    input  logic               areset,
    input  logic               clear,
    input  logic               push,
    input  logic               pop,
    input  FilterCondFifoEntry wdata,
    output FilterCondFifoEntry head,
    output logic               head_valid,
    output logic               full,
    output logic [AW:0]        occupancy
);

    FilterCondFifoEntry mem [DEPTH];
    logic [AW:0]        wr_ptr, rd_ptr;
    logic [AW:0]        wr_ptr_n, rd_ptr_n, occ_n;
    FilterCondFifoEntry head_n;
    logic               do_pop;

    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign occupancy = wr_ptr - rd_ptr;
    assign do_pop    = pop & head_valid;

    // Next pointers and next head; a push landing in the slot about to
    // become the head bypasses the array so empty->valid takes one edge.
    always_comb begin
        wr_ptr_n = wr_ptr + (AW+1)'(push);
        rd_ptr_n = rd_ptr + (AW+1)'(do_pop);
        occ_n    = wr_ptr_n - rd_ptr_n;
        head_n   = head;
        if (occ_n != '0) begin
            if (push && (rd_ptr_n == wr_ptr)) begin
                head_n = wdata;
            end else begin
                head_n = mem[rd_ptr_n[AW-1:0]];
            end
        end
    end

    // Pointer and head registers; clear wins over push and pop.
    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            head       <= '0;
            head_valid <= 1'b0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            head       <= '0;
            head_valid <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr_n;
            rd_ptr     <= rd_ptr_n;
            head       <= head_n;
            head_valid <= (occ_n != '0);
        end
    end

    // Storage array write; contents need no reset.
    always_ff @(posedge ap_clk) begin
        if (push && !clear) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/engine_filter_cond_result_stage.sv
// Result stage behind the filter-condition kernel: applies the pass/drop
// policy, pulses on failing conditions, buffers survivors and keeps stats.
//
// Handshake: a packet leaves on a clock edge where out_valid && out_ready;
// out_valid never depends on out_ready, and out_data/out_flag stay stable
// while out_valid && !out_ready.
module engine_filter_cond_result_stage
    import engine_filter_cond_result_stage_pkg::*;
#(
    parameter int FIFO_DEPTH       = 16,
    parameter int PROG_FULL_MARGIN = 3,
    parameter int COUNT_W          = 32
) (
    input  logic                  ap_clk,
    input  logic                  areset,
    input  logic                  clear,
    input  logic                  config_params_valid,
    input  FilterCondResultConfig config_params,
    input  logic                  result_valid_in,
    input  logic                  result_flag_in,
    input  MemoryPacketData       result_data_in,
    output logic                  prog_full,
    output logic                  out_valid,
    input  logic                  out_ready,
    output MemoryPacketData       out_data,
    output logic                  out_flag,
    output logic                  break_pulse,
    output logic [COUNT_W-1:0]    pass_count,
    output logic [COUNT_W-1:0]    drop_count,
    output logic                  overflow_sticky
);

    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PF_THRESH = (AW+1)'(FIFO_DEPTH - PROG_FULL_MARGIN);

    logic               qualified, keep, drop, pop, write, lost, fifo_full;
    logic [AW:0]        occupancy, occ_next;
    FilterCondFifoEntry wdata, head;

    // An input in a clear cycle is discarded along with everything else.
    assign qualified = result_valid_in & config_params_valid & ~clear;
    assign keep      = qualified & keep_packet(config_params.pass_mode, result_flag_in);
    assign drop      = qualified & ~keep_packet(config_params.pass_mode, result_flag_in);
    assign pop       = out_valid & out_ready;
    assign write     = keep & (~fifo_full | pop);
    assign lost      = keep & fifo_full & ~pop;
    assign occ_next  = occupancy + (AW+1)'(write) - (AW+1)'(pop);
    assign wdata     = '{data: result_data_in, flag: result_flag_in};
    assign out_data  = head.data;
    assign out_flag  = head.flag;

    engine_filter_cond_result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .ap_clk     (ap_clk),
        .areset     (areset),
        .clear      (clear),
        .push       (write),
        .pop        (pop),
        .wdata      (wdata),
        .head       (head),
        .head_valid (out_valid),
        .full       (fifo_full),
        .occupancy  (occupancy)
    );

    // Throttle and break pulse, both registered from this cycle's activity.
    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            prog_full   <= 1'b0;
            break_pulse <= 1'b0;
        end else if (clear) begin
            prog_full   <= 1'b0;
            break_pulse <= 1'b0;
        end else begin
            prog_full   <= (occ_next >= PF_THRESH);
            break_pulse <= qualified & ~result_flag_in & config_params.break_on_false;
        end
    end

    // Saturating statistics and the sticky overflow flag.
    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            pass_count      <= '0;
            drop_count      <= '0;
            overflow_sticky <= 1'b0;
        end else if (clear) begin
            pass_count      <= '0;
            drop_count      <= '0;
            overflow_sticky <= 1'b0;
        end else begin
            if (write && (pass_count != '1)) begin
                pass_count <= pass_count + COUNT_W'(1);
            end
            if (drop && (drop_count != '1)) begin
                drop_count <= drop_count + COUNT_W'(1);
            end
            if (lost) begin
                overflow_sticky <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_engine_filter_cond_result_stage.sv
// Bench for engine_filter_cond_result_stage: scenario tasks driving a
// queue-based scoreboard that is checked every cycle on the falling edge.
module tb_engine_filter_cond_result_stage;
    import engine_filter_cond_result_stage_pkg::*;

    localparam int DEPTH = 16;
    localparam int PF_AT = DEPTH - 3;

    logic                  ap_clk = 1'b0;
    logic                  areset;
    logic                  clear;
    logic                  config_params_valid;
    FilterCondResultConfig config_params;
    logic                  result_valid_in;
    logic                  result_flag_in;
    MemoryPacketData       result_data_in;
    logic                  prog_full;
    logic                  out_valid;
    logic                  out_ready;
    MemoryPacketData       out_data;
    logic                  out_flag;
    logic                  break_pulse;
    logic [31:0]           pass_count;
    logic [31:0]           drop_count;
    logic                  overflow_sticky;

    logic [64:0] exp_q[$];
    logic        exp_brk, exp_pf, exp_ovf;
    logic [31:0] exp_pass, exp_drop;
    int          checks, failures, n_out, n_brk;

    engine_filter_cond_result_stage #(
        .FIFO_DEPTH       (DEPTH),
        .PROG_FULL_MARGIN (3),
        .COUNT_W          (32)
    ) dut (
        .ap_clk              (ap_clk),
        .areset              (areset),
        .clear               (clear),
        .config_params_valid (config_params_valid),
        .config_params       (config_params),
        .result_valid_in     (result_valid_in),
        .result_flag_in      (result_flag_in),
        .result_data_in      (result_data_in),
        .prog_full           (prog_full),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_data            (out_data),
        .out_flag            (out_flag),
        .break_pulse         (break_pulse),
        .pass_count          (pass_count),
        .drop_count          (drop_count),
        .overflow_sticky     (overflow_sticky)
    );

    // clock
    always #5 ap_clk = ~ap_clk;

    // scoreboard: per-cycle state checks, pop and compare on each transfer
    always @(negedge ap_clk) begin
        if (!areset) begin
            checks++;
            if (out_valid !== (exp_q.size() > 0)) begin
                failures++;
                $display("FAIL out_valid: got %b expected %b", out_valid, exp_q.size() > 0);
            end
            checks++;
            if (break_pulse !== exp_brk) begin
                failures++;
                $display("FAIL break_pulse: got %b expected %b at %0t", break_pulse, exp_brk, $time);
            end
            checks++;
            if (prog_full !== exp_pf) begin
                failures++;
                $display("FAIL prog_full: got %b expected %b at %0t", prog_full, exp_pf, $time);
            end
            if (break_pulse) n_brk++;
            if (out_valid && out_ready && exp_q.size() > 0) begin
                checks++;
                if ({out_flag, out_data} !== exp_q[0]) begin
                    failures++;
                    $display("FAIL head_entry: got %h expected %h", {out_flag, out_data}, exp_q[0]);
                end
                void'(exp_q.pop_front());
                n_out++;
            end
        end
    end

    // Drive one cycle of input at posedge+1, then update the model after the edge.
    task automatic drive_cycle(input logic v, input logic f, input logic do_clear,
                               output logic [63:0] d);
        logic qual, keep, pop_m, wr;
        int   sz;
        d = {$urandom, $urandom};
        clear           = do_clear;
        result_valid_in = v;
        result_flag_in  = f;
        result_data_in  = d;
        sz    = exp_q.size();
        qual  = v && config_params_valid && !do_clear;
        case (config_params.pass_mode)
            PASS_TRUE:  keep = qual && f;
            PASS_FALSE: keep = qual && !f;
            default:    keep = qual;
        endcase
        pop_m = out_ready && (sz > 0);
        wr    = keep && ((sz < DEPTH) || pop_m);
        @(posedge ap_clk);
        #1;
        if (do_clear) begin
            exp_q.delete();
            exp_pass = 0;
            exp_drop = 0;
            exp_ovf  = 0;
            exp_brk  = 0;
            exp_pf   = 0;
        end else begin
            if (wr) begin
                exp_q.push_back({f, d});
                if (exp_pass != '1) exp_pass++;
            end
            if (qual && !keep && exp_drop != '1) exp_drop++;
            if (keep && !wr) exp_ovf = 1;
            exp_brk = qual && !f && config_params.break_on_false;
            exp_pf  = exp_q.size() >= PF_AT;
        end
        clear           = 1'b0;
        result_valid_in = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge ap_clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        checks++; if (prog_full !== 1'b0) begin failures++; $display("FAIL reset_prog_full: got %b expected 0", prog_full); end
        checks++; if (break_pulse !== 1'b0) begin failures++; $display("FAIL reset_break: got %b expected 0", break_pulse); end
        checks++; if (pass_count !== 0 || drop_count !== 0) begin failures++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", pass_count, drop_count); end
        checks++; if (overflow_sticky !== 1'b0) begin failures++; $display("FAIL reset_sticky: got %b expected 0", overflow_sticky); end
        areset = 1'b0;
    endtask

    task automatic test_pass_true();
        logic [7:0]  flags;
        logic [63:0] d;
        int          out0;
        flags = 8'b1100_1101;   // sent LSB first: 1,0,1,1,0,0,1,1
        config_params       = '{pass_mode: PASS_TRUE, break_on_false: 1'b0};
        config_params_valid = 1'b1;
        out_ready           = 1'b1;
        out0                = n_out;
        for (int i = 0; i < 8; i++) drive_cycle(1'b1, flags[i], 1'b0, d);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 1'b0, d);
        checks++; if (n_out - out0 != 5) begin failures++; $display("FAIL pass_true_outputs: got %0d expected 5", n_out - out0); end
        checks++; if (pass_count !== 32'd5) begin failures++; $display("FAIL pass_true_pass_count: got %0d expected 5", pass_count); end
        checks++; if (drop_count !== 32'd3) begin failures++; $display("FAIL pass_true_drop_count: got %0d expected 3", drop_count); end
    endtask

    task automatic test_pass_all_break();
        logic [63:0] d;
        int          brk0, out0;
        drive_cycle(1'b0, 1'b0, 1'b1, d);
        config_params = '{pass_mode: PASS_ALL, break_on_false: 1'b1};
        out_ready     = 1'b1;
        brk0          = n_brk;
        out0          = n_out;
        drive_cycle(1'b1, 1'b1, 1'b0, d);
        drive_cycle(1'b1, 1'b0, 1'b0, d);
        drive_cycle(1'b1, 1'b0, 1'b0, d);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 1'b0, d);
        checks++; if (n_brk - brk0 != 2) begin failures++; $display("FAIL break_count: got %0d expected 2", n_brk - brk0); end
        checks++; if (n_out - out0 != 3) begin failures++; $display("FAIL pass_all_outputs: got %0d expected 3", n_out - out0); end
        checks++; if (pass_count !== 32'd3) begin failures++; $display("FAIL pass_all_pass_count: got %0d expected 3", pass_count); end
    endtask

    task automatic test_fill_overflow();
        logic [63:0] d, first;
        drive_cycle(1'b0, 1'b0, 1'b1, d);
        config_params = '{pass_mode: PASS_ALL, break_on_false: 1'b0};
        out_ready     = 1'b0;
        first         = '0;
        for (int i = 0; i < DEPTH; i++) begin
            drive_cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, d);
            if (i == 0) first = d;
            if (i == PF_AT - 2) begin
                checks++; if (prog_full !== 1'b0) begin failures++; $display("FAIL prog_full_below: got %b expected 0", prog_full); end
            end
            if (i == PF_AT - 1) begin
                checks++; if (prog_full !== 1'b1) begin failures++; $display("FAIL prog_full_at: got %b expected 1", prog_full); end
            end
        end
        checks++; if (overflow_sticky !== 1'b0) begin failures++; $display("FAIL sticky_before: got %b expected 0", overflow_sticky); end
        drive_cycle(1'b1, 1'b1, 1'b0, d);
        checks++; if (overflow_sticky !== 1'b1) begin failures++; $display("FAIL sticky_after: got %b expected 1", overflow_sticky); end
        checks++; if (pass_count !== 32'd16) begin failures++; $display("FAIL full_pass_count: got %0d expected 16", pass_count); end
        checks++; if (out_data !== first) begin failures++; $display("FAIL head_held: got %h expected %h", out_data, first); end
    endtask

    task automatic test_full_push_pop();
        logic [63:0] d;
        drive_cycle(1'b0, 1'b0, 1'b1, d);
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) drive_cycle(1'b1, 1'b1, 1'b0, d);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) drive_cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, d);
        out_ready = 1'b0;
        checks++; if (overflow_sticky !== 1'b0) begin failures++; $display("FAIL push_pop_sticky: got %b expected 0", overflow_sticky); end
        checks++; if (pass_count !== 32'd26) begin failures++; $display("FAIL push_pop_pass_count: got %0d expected 26", pass_count); end
        checks++; if (exp_q.size() != DEPTH || prog_full !== 1'b1) begin failures++; $display("FAIL push_pop_occupancy: got pf=%b size=%0d expected pf=1 size=16", prog_full, exp_q.size()); end
    endtask

    task automatic test_clear();
        logic [63:0] d;
        drive_cycle(1'b0, 1'b0, 1'b1, d);
        config_params = '{pass_mode: PASS_ALL, break_on_false: 1'b1};
        out_ready     = 1'b0;
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, 1'b1, 1'b0, d);
        drive_cycle(1'b1, 1'b0, 1'b1, d);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL clear_out_valid: got %b expected 0", out_valid); end
        checks++; if (pass_count !== 0 || drop_count !== 0) begin failures++; $display("FAIL clear_counts: got %0d/%0d expected 0/0", pass_count, drop_count); end
        checks++; if (overflow_sticky !== 1'b0 || break_pulse !== 1'b0) begin failures++; $display("FAIL clear_flags: got sticky=%b brk=%b expected 0/0", overflow_sticky, break_pulse); end
        drive_cycle(1'b0, 1'b0, 1'b0, d);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL clear_input_dropped: got %b expected 0", out_valid); end
    endtask

    task automatic test_config_invalid_reset();
        logic [63:0] d;
        config_params       = '{pass_mode: PASS_ALL, break_on_false: 1'b1};
        config_params_valid = 1'b0;
        out_ready           = 1'b0;
        for (int i = 0; i < 6; i++) drive_cycle(1'(i % 2 == 0), 1'b0, 1'b0, d);
        checks++; if (pass_count !== 0 || drop_count !== 0) begin failures++; $display("FAIL invalid_counts: got %0d/%0d expected 0/0", pass_count, drop_count); end
        config_params_valid = 1'b1;
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b1, 1'b0, d);
        checks++; if (pass_count !== 32'd3) begin failures++; $display("FAIL burst_pass_count: got %0d expected 3", pass_count); end
        result_valid_in = 1'b1;
        result_flag_in  = 1'b0;
        #3;
        areset = 1'b1;
        exp_q.delete();
        exp_pass = 0; exp_drop = 0; exp_ovf = 0; exp_brk = 0; exp_pf = 0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== '0 || out_flag !== 1'b0) begin failures++; $display("FAIL async_reset_head: got v=%b d=%h f=%b expected 0", out_valid, out_data, out_flag); end
        checks++; if (pass_count !== 0 || drop_count !== 0 || overflow_sticky !== 1'b0 || prog_full !== 1'b0 || break_pulse !== 1'b0) begin failures++; $display("FAIL async_reset_state: got p=%0d d=%0d s=%b pf=%b b=%b expected 0", pass_count, drop_count, overflow_sticky, prog_full, break_pulse); end
        @(posedge ap_clk);
        #1;
        areset          = 1'b0;
        result_valid_in = 1'b0;
        drive_cycle(1'b1, 1'b1, 1'b0, d);
        checks++; if (out_valid !== 1'b1 || out_data !== d) begin failures++; $display("FAIL post_reset_write: got v=%b d=%h expected 1 %h", out_valid, out_data, d); end
        checks++; if (pass_count !== 32'd1) begin failures++; $display("FAIL post_reset_pass_count: got %0d expected 1", pass_count); end
    endtask

    initial begin
        checks = 0; failures = 0; n_out = 0; n_brk = 0;
        exp_brk = 0; exp_pf = 0; exp_ovf = 0; exp_pass = 0; exp_drop = 0;
        areset = 1'b1; clear = 1'b0; config_params_valid = 1'b0;
        config_params   = '{pass_mode: PASS_TRUE, break_on_false: 1'b0};
        result_valid_in = 1'b0; result_flag_in = 1'b0; result_data_in = '0;
        out_ready       = 1'b0;
        test_reset();
        test_pass_true();
        test_pass_all_break();
        test_fill_overflow();
        test_full_push_pop();
        test_clear();
        test_config_invalid_reset();
        checks++; if (overflow_sticky !== exp_ovf) begin failures++; $display("FAIL final_sticky: got %b expected %b", overflow_sticky, exp_ovf); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/engine_filter_cond_result_stage.md
Name: engine_filter_cond_result_stage

Overview:
- Downstream neighbour of engine_filter_cond_kernel. Consumes the kernel's registered result_flag/result_data plus an aligned valid.
- Applies the configured pass/drop policy and emits a one-cycle break indication on a failing condition.
- Buffers surviving packets in a small show-ahead FIFO with a valid/ready handshake toward the engine's output arbiter.
- Keeps saturating pass/drop statistics and gives the upstream issue logic an early-full throttle, because the kernel itself cannot stall.

Parameters:
- FIFO_DEPTH, 16, number of buffered result entries; power of two, >= 4.
- PROG_FULL_MARGIN, 3, prog_full asserts when occupancy >= FIFO_DEPTH - PROG_FULL_MARGIN; covers kernel latency plus issue latency.
- COUNT_W, 32, width of the pass/drop statistics counters.

Ports:
- ap_clk  in  1  clock
- areset  in  1  asynchronous, active-high reset
- clear  in  1  synchronous flush of FIFO, counters and sticky flags
- config_params_valid  in  1  configuration is live; when low, all inputs are discarded
- config_params  in  $bits(FilterCondResultConfig)  fields: pass_mode (PASS_TRUE, PASS_FALSE, PASS_ALL), break_on_false (1 bit)
- result_valid_in  in  1  kernel result valid; upstream delays data_valid by one cycle to match the kernel's register
- result_flag_in  in  1  kernel result_flag
- result_data_in  in  $bits(MemoryPacketData)  kernel result_data
- prog_full  out  1  throttle to the upstream issuer
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts the head
- out_data  out  $bits(MemoryPacketData)  head data
- out_flag  out  1  head flag; meaningful in PASS_ALL
- break_pulse  out  1  one-cycle pulse on a failing-condition packet
- pass_count  out  COUNT_W  packets written to the FIFO, saturating
- drop_count  out  COUNT_W  packets filtered out by policy, saturating
- overflow_sticky  out  1  a packet that should have been written was lost because the FIFO was full

Behaviour:
- Reset (areset, async) values: prog_full=0, out_valid=0, out_data=0, out_flag=0, break_pulse=0, counts=0, overflow_sticky=0, FIFO empty.
- Reset deasserted mid-traffic: the first input is sampled on the first clock edge after deassertion.
- Qualify: in = result_valid_in & config_params_valid. If config_params_valid=0, inputs are ignored: no write, no count, no pulse.
- Keep decision:
  - PASS_TRUE keeps flag=1.
  - PASS_FALSE keeps flag=0.
  - PASS_ALL keeps every packet.
  - A non-kept qualified packet increments drop_count.
- break_pulse: asserted the cycle after a qualified packet with flag=0 when break_on_false=1. Independent of the keep decision and of FIFO fullness.
- Write: keep & (occupancy<FIFO_DEPTH | pop same cycle).
  - A successful write increments pass_count.
  - keep with the FIFO full and no pop sets overflow_sticky; the packet is discarded and not counted.
- Pop: out_valid & out_ready.
- FIFO is show-ahead, with a registered head.
  - A write into an empty FIFO at edge N gives out_valid=1 after edge N, i.e. one-cycle latency.
  - The head holds stable while out_valid & !out_ready.
- Simultaneous push and pop: occupancy unchanged. Full + push + pop is legal. Empty + push + pop is impossible because out_valid=0.
- prog_full is registered from post-update occupancy and deasserts as soon as occupancy falls below the threshold.
- Counters saturate at 2^COUNT_W-1 and do not wrap.
- Pointer wrap: log2(FIFO_DEPTH)+1-bit pointers; full/empty come from MSB compare.
- clear:
  - Priority over push and pop in the same cycle.
  - Empties the FIFO, zeroes the counters, clears overflow_sticky, forces break_pulse=0 the next cycle.
  - An input arriving in the clear cycle is discarded.
- A config change while the FIFO is non-empty does not alter buffered entries; the new policy applies from the next qualified input.

Decomposition:
- PKG_ENGINE:
  - typedef enum FilterCondPassMode {PASS_TRUE, PASS_FALSE, PASS_ALL}
  - struct FilterCondResultConfig {pass_mode, break_on_false}
  - FIFO entry struct {MemoryPacketData data; logic flag}
- Sub-module engine_filter_cond_result_fifo: parameterised show-ahead FIFO with push/pop/clear and occupancy output. The top level holds the policy, counters, pulse and throttle logic.

Test Plan:
- PASS_TRUE, 8 packets with flags 1,0,1,1,0,0,1,1, out_ready=1 -> 5 outputs in order, pass_count=5, drop_count=3, no break_pulse while break_on_false=0.
- PASS_ALL + break_on_false=1, flags 1,0,0 -> 3 outputs with out_flag=1,0,0; break_pulse high on exactly 2 cycles, each one cycle after its input.
- FIFO_DEPTH=16, out_ready=0, 16 kept writes -> prog_full high from occupancy 13; the 17th write sets overflow_sticky, pass_count=16, out_data held at entry 0.
- Full FIFO, simultaneous push and pop for 10 cycles -> occupancy stays 16, ordering preserved, overflow_sticky stays 0.
- clear asserted with 5 entries and a concurrent valid input -> next cycle out_valid=0, counts=0, sticky=0, the concurrent input is not written.
- config_params_valid=0 with result_valid_in toggling; then areset pulsed asynchronously mid-burst -> no writes or counts while config is invalid; all outputs 0 immediately on areset, without waiting for a clock edge.
